// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit
//   op_e     request opcodes (loads 0..4, stores 5..7)
//   ERR_*    response error codes
//   state_e  bus sequencer states
//   TIMEOUT_DEFAULT  read-acknowledge wait limit in cycles
package lsu_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_e;

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_NOACK    = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_MREAD,
        S_WRITE,
        S_WWAIT,
        S_RESP
    } state_e;

    localparam int TIMEOUT_DEFAULT = 16;

    function automatic logic misaligned(op_e op, logic [1:0] off);
        return (op == OP_LW || op == OP_SW) ? (off != 2'b00) :
               (op == OP_LH || op == OP_LHU || op == OP_SH) ? off[0] : 1'b0;
    endfunction

endpackage

// File: rtl/load_store_unit_lane.sv
// lsu_lane: byte/halfword lane extraction and merge
//   op         opcode selecting width and extension
//   off        byte offset within the word
//   rword      word read from the bus
//   wlow       low halfword of the store data
//   load_data  extracted, extended load result
//   merged     rword with the addressed lane(s) replaced by store data
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  off,
    input  logic [31:0] rword,
    input  logic [15:0] wlow,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b         = rword[8*off +: 8];
        h         = off[1] ? rword[31:16] : rword[15:0];
        load_data = op == OP_LB  ? {{24{b[7]}}, b} :
                    op == OP_LBU ? {24'b0, b} :
                    op == OP_LH  ? {{16{h[15]}}, h} :
                    op == OP_LHU ? {16'b0, h} : rword;
        merged    = rword;
        if (op == OP_SB)
            merged[8*off +: 8] = wlow[7:0];
        else if (op == OP_SH)
            merged[16*off[1] +: 16] = wlow;
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage bus initiator for word-aligned loads/stores
//   clk, reset            clock; asynchronous active-low reset
//   req_valid/ready       request handshake (ready only in IDLE)
//   req_op/addr/wdata     opcode, byte address, store data
//   resp_valid            one-cycle completion pulse
//   resp_rdata/err        extended load data; error code
//   bus_read/write        bus strobes (mutually exclusive)
//   bus_addr/wdata        word-aligned address and write data
//   bus_rdata             read data
//   bus_read_acc          same-cycle read acknowledge
//   bus_write_acc         acknowledge one cycle after the write strobe
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_read_acc,
    input  logic        bus_write_acc
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     data_q, data_d;
    logic [1:0]      err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     load_data, merged;
    op_e             req_op_e;

    assign req_op_e = op_e'(req_op);

    lsu_lane u_lane (
        .op        (op_q),
        .off       (addr_q[1:0]),
        .rword     (bus_rdata),
        .wlow      (wdata_q[15:0]),
        .load_data (load_data),
        .merged    (merged)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (req_valid) begin
                op_d    = req_op_e;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                data_d  = '0;
                cnt_d   = '0;
                err_d   = misaligned(req_op_e, req_addr[1:0]) ? ERR_MISALIGN : ERR_OK;
                state_d = misaligned(req_op_e, req_addr[1:0]) ? S_RESP :
                          req_op_e == OP_SW ? S_WRITE :
                          (req_op_e == OP_SH || req_op_e == OP_SB) ? S_MREAD : S_READ;
            end
            S_READ, S_MREAD: if (bus_read_acc) begin
                // A load finishes here; a partial store carries the merged word into WRITE.
                state_d = state_q == S_READ ? S_RESP : S_WRITE;
                if (state_q == S_READ)
                    data_d = load_data;
                else
                    wdata_d = merged;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                err_d   = ERR_TIMEOUT;
                state_d = S_RESP;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            S_WRITE: state_d = S_WWAIT;
            S_WWAIT: begin
                err_d   = bus_write_acc ? ERR_OK : ERR_NOACK;
                state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_LW;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            err_q   <= ERR_OK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready  = state_q == S_IDLE;
    assign resp_valid = state_q == S_RESP;
    assign resp_rdata = resp_valid ? data_q : '0;
    assign resp_err   = resp_valid ? err_q : ERR_OK;
    assign bus_read   = state_q == S_READ || state_q == S_MREAD;
    assign bus_write  = state_q == S_WRITE;
    assign bus_addr   = {addr_q[31:2], 2'b00};
    assign bus_wdata  = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench with a memory responder and reference model
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        bus_read, bus_write;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_read_acc;
    logic        bus_write_acc = 1'b0;

    load_store_unit dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .bus_read      (bus_read),
        .bus_write     (bus_write),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_rdata     (bus_rdata),
        .bus_read_acc  (bus_read_acc),
        .bus_write_acc (bus_write_acc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
        int          lat;
        int          nrd;
        int          nwr;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          checks = 0, errors = 0;
    int          cyc = 0, acc_cyc = 0, resp_cnt = 0, wr_total = 0;
    int          nrd_c = 0, nwr_c = 0;
    logic        prev_rd = 0, prev_wr = 0;
    logic [31:0] prev_addr = 0, prev_wd = 0;
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    bit          rd_en = 1, wack_en = 1, zero_wait = 1;
    logic        rd_ok = 0;

    always @(posedge clk) cyc++;

    // responder: combinational read ack with optional wait states, registered write ack
    assign bus_rdata    = mem[bus_addr[9:2]];
    assign bus_read_acc = bus_read && rd_ok;
    always @(posedge clk) begin
        rd_ok         <= rd_en && (zero_wait || $urandom_range(0, 3) != 0);
        bus_write_acc <= bus_write && wack_en;
        if (bus_write && wack_en)
            mem[bus_addr[9:2]] <= bus_wdata;
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    task automatic fail_now(string nm);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", nm);
    endtask

    // reference model: expected response from the memory image and the request rules
    function automatic exp_t model(int op, logic [31:0] a, logic [31:0] d, bit live, bit wack, bit zw);
        exp_t        e;
        int          idx = int'(a[9:2]);
        int          sh = int'(a[1:0]) * 8;
        int          hs = int'(a[1]) * 16;
        logic [31:0] old = ref_mem[idx];
        logic [31:0] bv = (old >> sh) & 32'hFF;
        logic [31:0] hv = (old >> hs) & 32'hFFFF;
        logic [31:0] nw;
        bit          mis = (op == 0 || op == 5) ? a[1:0] != 0 :
                           (op == 1 || op == 2 || op == 6) ? a[0] : 1'b0;
        bit          rd = op != 5;
        bit          ld = op <= 4;
        e = '{rdata: 0, err: 0, lat: -1, nrd: -1, nwr: 0};
        if (mis) begin
            e.err = 1; e.lat = 1; e.nrd = 0;
        end else if (rd && !live) begin
            e.err = 2; e.lat = 17; e.nrd = 16;
        end else begin
            e.nrd = rd ? (zw ? 1 : -1) : 0;
            e.lat = zw ? (ld ? 2 : op == 5 ? 3 : 4) : (rd ? -1 : 3);
            if (ld) begin
                case (op)
                    0:       e.rdata = old;
                    1:       e.rdata = hv[15] ? hv | 32'hFFFF0000 : hv;
                    2:       e.rdata = hv;
                    3:       e.rdata = bv[7] ? bv | 32'hFFFFFF00 : bv;
                    default: e.rdata = bv;
                endcase
            end else begin
                e.nwr = 1;
                nw = op == 5 ? d :
                     op == 7 ? (old & ~(32'hFF << sh)) | ((d & 32'hFF) << sh) :
                               (old & ~(32'hFFFF << hs)) | ((d & 32'hFFFF) << hs);
                if (wack) ref_mem[idx] = nw;
                else e.err = 3;
            end
        end
        return e;
    endfunction

    task automatic issue(int op, logic [31:0] a, logic [31:0] d);
        int n0;
        @(negedge clk);
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
        if (!req_ready) fail_now("req_ready_wait");
        q.push_back(model(op, a, d, rd_en, wack_en, zero_wait));
        n0        = resp_cnt;
        req_valid = 1'b1;
        req_op    = op[2:0];
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #1 acc_cyc = cyc;
        req_valid = 1'b0;
        for (int i = 0; i < 40 && resp_cnt == n0; i++) @(negedge clk);
        if (resp_cnt == n0) fail_now("resp_wait");
    endtask

    // monitor: protocol checks every cycle, scoreboard pop on each response
    always @(negedge clk) begin
        if (!reset) begin
            nrd_c = 0; nwr_c = 0; prev_rd = 0; prev_wr = 0;
        end else begin
            if (bus_read || bus_write) begin
                chk("strobe_exclusive", {31'b0, bus_read && bus_write}, 0);
                chk("bus_addr_align", {30'b0, bus_addr[1:0]}, 0);
                if ((bus_read && prev_rd) || (bus_write && prev_wr)) begin
                    chk("bus_addr_stable", bus_addr, prev_addr);
                    chk("bus_wdata_stable", bus_wdata, prev_wd);
                end
            end
            prev_rd   = bus_read;
            prev_wr   = bus_write;
            prev_addr = bus_addr;
            prev_wd   = bus_wdata;
            nrd_c    += int'(bus_read);
            nwr_c    += int'(bus_write);
            wr_total += int'(bus_write);
            if (resp_valid) begin
                if (q.size() == 0) begin
                    fail_now("unexpected_resp");
                end else begin
                    mon_e = q.pop_front();
                    chk("resp_rdata", resp_rdata, mon_e.rdata);
                    chk("resp_err", {30'b0, resp_err}, {30'b0, mon_e.err});
                    if (mon_e.lat >= 0) chk("latency", cyc - acc_cyc + 1, mon_e.lat);
                    if (mon_e.nrd >= 0) chk("read_cycles", nrd_c, mon_e.nrd);
                    chk("write_cycles", nwr_c, mon_e.nwr);
                end
                nrd_c = 0;
                nwr_c = 0;
                resp_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          op, wt;
        logic [31:0] a;
        for (int i = 0; i < 256; i++) begin
            a = $urandom;
            mem[i] <= a;
            ref_mem[i] = a;
        end
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 0);
        chk("rst_bus_read", {31'b0, bus_read}, 0);
        chk("rst_bus_write", {31'b0, bus_write}, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_resp_err", {30'b0, resp_err}, 0);
        reset = 1'b1;

        issue(5, 32'h10, 32'h12345678);
        issue(0, 32'h10, 0);
        issue(5, 32'h20, 32'h80FF7F01);
        issue(3, 32'h23, 0);
        issue(4, 32'h23, 0);
        issue(1, 32'h22, 0);
        issue(2, 32'h20, 0);
        issue(5, 32'h20, 32'h11223344);
        issue(7, 32'h21, 32'hAB);
        issue(0, 32'h20, 0);
        issue(6, 32'h22, 32'hBEEF);
        issue(0, 32'h20, 0);
        issue(0, 32'h02, 0);
        issue(6, 32'h05, 32'h1234);
        rd_en = 0;
        issue(0, 32'h2000_0000, 0);
        issue(7, 32'h40, 32'h77);
        rd_en = 1;
        wack_en = 0;
        issue(5, 32'h44, 32'h55);
        wack_en = 1;

        rd_en = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd7; req_addr = 32'h31; req_wdata = 32'h5A;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 chk("mid_rmw_bus_read", {31'b0, bus_read}, 1);
        wt = wr_total;
        reset = 1'b0;
        #1 chk("async_rst_bus_read", {31'b0, bus_read}, 0);
        chk("async_rst_req_ready", {31'b0, req_ready}, 1);
        chk("async_rst_bus_write", {31'b0, bus_write}, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        rd_en = 1;
        repeat (3) @(negedge clk);
        chk("rst_no_write", wr_total, wt);
        chk("rst_mem_unchanged", mem[12], ref_mem[12]);
        chk("rst_ready_after", {31'b0, req_ready}, 1);

        zero_wait = 0;
        for (int n = 0; n < 150; n++) begin
            op = $urandom_range(0, 7);
            a  = $urandom_range(0, 1023);
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            wack_en = $urandom_range(0, 9) != 0;
            issue(op, a, $urandom);
        end
        wack_en = 1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 256; i++) chk("final_mem", mem[i], ref_mem[i]);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
